// File: rtl/dram_readback_tx_if.sv
// Start/busy/done handshake, RAM read port and UART line for dram_readback_tx.
interface dram_readback_tx_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic              tx;
    logic [ADDR_W-1:0] dpra;
    logic              dpo;

    // master: the requester plus the RAM (drives start and dpo)
    modport master (
        output start,
        output dpo,
        input  busy,
        input  done,
        input  tx,
        input  dpra
    );

    // slave: the readback transmitter
    modport slave (
        input  start,
        input  dpo,
        output busy,
        output done,
        output tx,
        output dpra
    );
endinterface

// File: rtl/dram_readback_tx.sv
// Sweeps the distributed RAM read port, packs DPO bits into bytes and sends
// them LSB first over a UART 8N1 line.
module dram_readback_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    dram_readback_tx_if.slave bus
);
    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam int unsigned NUM_BYTES = DEPTH / 8;
    localparam int unsigned BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned FCNT_W    = 4;

    localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST  = BYTE_W'(NUM_BYTES - 1);
    localparam logic [FCNT_W-1:0] FETCH_LAST = FCNT_W'(8);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND_START,
        SEND_DATA,
        SEND_STOP,
        FIN
    } state_e;

    state_e             state_q,     state_d;
    logic [BYTE_W-1:0]  byte_idx_q,  byte_idx_d;
    logic [FCNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]   clk_cnt_q,   clk_cnt_d;
    logic [2:0]         bit_idx_q,   bit_idx_d;
    logic [7:0]         shift_q,     shift_d;
    logic [ADDR_W-1:0]  dpra_q,      dpra_d;
    logic               tx_q,        tx_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               dpo_q;
    logic               bit_end_c;

    // Byte-aligned RAM address: {byte index, bit offset}
    function automatic logic [ADDR_W-1:0] addr_of(input logic [BYTE_W-1:0] b,
                                                  input logic [2:0]        k);
        return ADDR_W'({b, k});
    endfunction

    // End of the current UART bit period
    assign bit_end_c = (clk_cnt_q == BIT_LAST);

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        fetch_cnt_d = fetch_cnt_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        dpra_d      = dpra_q;
        tx_d        = 1'b1;
        busy_d      = 1'b1;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d     = FETCH;
                    fetch_cnt_d = '0;
                    dpra_d      = addr_of(byte_idx_q, 3'd0);
                end
            end

            // Address k goes out in cycle k; its DPO value is captured into
            // dpo_q at the end of that cycle and lands in shift bit k one cycle
            // later, so nine cycles cover eight addresses.
            FETCH: begin
                if (fetch_cnt_q != '0) begin
                    shift_d[3'(fetch_cnt_q - FCNT_W'(1))] = dpo_q;
                end
                if (fetch_cnt_q < FCNT_W'(7)) begin
                    dpra_d = addr_of(byte_idx_q, 3'(fetch_cnt_q + FCNT_W'(1)));
                end
                if (fetch_cnt_q == FETCH_LAST) begin
                    state_d     = SEND_START;
                    fetch_cnt_d = '0;
                    clk_cnt_d   = '0;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + FCNT_W'(1);
                end
            end

            SEND_START: begin
                tx_d = 1'b0;
                if (bit_end_c) begin
                    state_d   = SEND_DATA;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            SEND_DATA: begin
                tx_d = shift_q[bit_idx_q];
                if (bit_end_c) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = SEND_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            SEND_STOP: begin
                tx_d = 1'b1;
                if (bit_end_c) begin
                    clk_cnt_d = '0;
                    if (byte_idx_q == BYTE_LAST) begin
                        state_d    = FIN;
                        byte_idx_d = '0;
                        dpra_d     = '0;
                    end else begin
                        state_d     = FETCH;
                        fetch_cnt_d = '0;
                        byte_idx_d  = byte_idx_q + BYTE_W'(1);
                        dpra_d      = addr_of(byte_idx_q + BYTE_W'(1), 3'd0);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            // Stay here through the done cycle so a start seen with done is dropped
            FIN: begin
                busy_d = 1'b0;
                done_d = ~done_q;
                if (done_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_idx_q  <= '0;
            fetch_cnt_q <= '0;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            dpra_q      <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dpo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            fetch_cnt_q <= fetch_cnt_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            dpra_q      <= dpra_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dpo_q       <= bus.dpo;
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dpra = dpra_q;

endmodule

// File: tb/tb_dram_readback_tx.sv
// Bench for dram_readback_tx: 32x1 RAM model, cycle-exact frame model, UART decode.
module tb_dram_readback_tx;
    localparam int CPB      = 4;
    localparam int AW       = 5;
    localparam int BYTE_CYC = 9 + 10 * CPB;        // 49
    localparam int DUMP_CYC = 4 * BYTE_CYC + 1;    // 197: done cycle after E0

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dram_readback_tx_if #(.ADDR_W(AW)) bus ();

    dram_readback_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 32x1 RAM: synchronous write port, asynchronous DPRA/DPO read
    logic [31:0] mem;
    logic        load;
    logic [31:0] load_val;
    logic        we;
    logic [4:0]  wa;
    logic        wd;

    always @(posedge clk) begin
        if (load)    mem     <= load_val;
        else if (we) mem[wa] <= wd;
    end
    assign bus.dpo = mem[bus.dpra];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected tx level n cycles after the start edge, for a dump of word w
    function automatic logic exp_tx(input int n, input logic [31:0] w);
        int b, off, slot;
        if (n < 10) return 1'b1;
        b   = (n - 10) / BYTE_CYC;
        off = (n - 10) - b * BYTE_CYC;
        if (b > 3 || off >= 10 * CPB) return 1'b1;
        slot = off / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return w[8 * b + slot - 1];
    endfunction

    task automatic set_mem(input logic [31:0] w);
        @(negedge clk);
        load = 1'b1; load_val = w;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wr_port(input logic [4:0] a, input logic v);
        @(negedge clk);
        we = 1'b1; wa = a; wd = v;
        @(negedge clk);
        we = 1'b0;
    endtask

    // One dump: checks every cycle against the frame model, decodes bytes at
    // mid-bit, optionally spams start, writes the RAM, or aborts with reset.
    task automatic run_dump(input logic [31:0] word, input bit spam, input int abort_at,
                            input int wr_at, input logic [4:0] wr_addr);
        logic [7:0] rx [4];
        bit         aborted;
        int         b, off, slot, fb, foff;
        logic       e_busy, e_done;
        aborted = 1'b0;
        for (int i = 0; i < 4; i++) rx[i] = '0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 0; n <= DUMP_CYC + 4; n++) begin
            if (n > 0) @(negedge clk);
            e_busy = (n >= 1 && n <= DUMP_CYC - 1);
            e_done = (n == DUMP_CYC);
            check($sformatf("sig@%0d", n), 32'({bus.busy, bus.done, bus.tx}),
                  32'({e_busy, e_done, exp_tx(n, word)}));
            fb   = n / BYTE_CYC;
            foff = n - fb * BYTE_CYC;
            if (fb < 4 && foff < 8)
                check($sformatf("dpra@%0d", n), 32'(bus.dpra), 32'(8 * fb + foff));
            if (n >= 10) begin
                b   = (n - 10) / BYTE_CYC;
                off = (n - 10) - b * BYTE_CYC;
                if (b < 4 && off < 10 * CPB && (off % CPB) == CPB / 2) begin
                    slot = off / CPB;
                    if (slot == 0)      check($sformatf("startbit%0d", b), 32'(bus.tx), 32'(0));
                    else if (slot == 9) check($sformatf("stopbit%0d", b), 32'(bus.tx), 32'(1));
                    else                rx[b][slot - 1] = bus.tx;
                end
            end
            if (n == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("abort", 32'({bus.tx, bus.busy, bus.done, bus.dpra}), 32'({1'b1, 1'b0, 1'b0, 5'd0}));
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            we = (n == wr_at); wa = wr_addr; wd = 1'b1;
            bus.start = spam && (((n % 3) == 0 && n < DUMP_CYC) || n == DUMP_CYC);
        end
        we = 1'b0;
        bus.start = 1'b0;
        if (!aborted)
            for (int i = 0; i < 4; i++)
                check($sformatf("byte%0d", i), 32'(rx[i]), 32'(word[8 * i +: 8]));
    endtask

    logic [31:0] w;

    initial begin
        rst = 1'b1; bus.start = 1'b0;
        load = 1'b0; load_val = '0; we = 1'b0; wa = '0; wd = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'({bus.tx, bus.busy, bus.done, bus.dpra}), 32'({1'b1, 1'b0, 1'b0, 5'd0}));

        // start together with reset: reset wins
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("rst_wins", 32'({bus.busy, bus.tx}), 32'({1'b0, 1'b1}));

        set_mem(32'h0000_0002);
        run_dump(32'h0000_0002, 1'b0, -1, -1, 5'd0);

        set_mem(32'hA5C3_0FF0);
        run_dump(32'hA5C3_0FF0, 1'b0, -1, -1, 5'd0);

        // start spam during a dump and in the done cycle, then one clean start
        w = $urandom();
        set_mem(w);
        run_dump(w, 1'b1, -1, -1, 5'd0);
        run_dump(w, 1'b0, -1, -1, 5'd0);

        // reset during SEND_DATA of byte 1, then a full frame from byte 0
        w = $urandom();
        set_mem(w);
        run_dump(w, 1'b0, BYTE_CYC + 10 + CPB + 2, -1, 5'd0);
        run_dump(w, 1'b0, -1, -1, 5'd0);

        // live read: mem[0] via write port before start, mem[31] during byte 0
        w = $urandom() & 32'h7FFF_FFFE;
        set_mem(w);
        wr_port(5'd0, 1'b1);
        run_dump(w | 32'h8000_0001, 1'b0, -1, 20, 5'd31);

        for (int r = 0; r < 3; r++) begin
            w = $urandom();
            set_mem(w);
            run_dump(w, 1'b0, -1, -1, 5'd0);
        end

        // long idle: line stays high, no done
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            check("idle", 32'({bus.done, bus.busy, bus.tx}), 32'({1'b0, 1'b0, 1'b1}));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
